// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Shared CPU package: datapath constants and the state encoding of the
// sequential multiplier.
// No ports (package).
// -----------------------------------------------------------------------------
package mul_seq_pkg;

  // Native datapath width of the CPU.
  localparam int unsigned XLEN  = 32;

  // Default operand width of the sequential multiplier.
  localparam int unsigned MUL_K = XLEN;

  // Multiplier FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage : mul_seq_pkg

// File: rtl/mul_seq_if.sv
// -----------------------------------------------------------------------------
// mul_seq_if
// Request/result bundle of the sequential multiplier.
//   start, sgn, a, b : request side (driven by the master)
//   busy, done       : status (driven by the multiplier)
//   hi, lo, zero     : 2K-bit product split into halves, plus zero flag
// Modports: master (requester), slave (multiplier).
// -----------------------------------------------------------------------------
interface mul_seq_if
  import mul_seq_pkg::*;
#(
  parameter int K = MUL_K
) ();

  logic         start;
  logic         sgn;
  logic [K-1:0] a;
  logic [K-1:0] b;
  logic         busy;
  logic         done;
  logic [K-1:0] hi;
  logic [K-1:0] lo;
  logic         zero;

  modport master (
    output start, sgn, a, b,
    input  busy, done, hi, lo, zero
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, hi, lo, zero
  );

endinterface : mul_seq_if

// File: rtl/mul_seq_adderk.sv
// -----------------------------------------------------------------------------
// adderk
// Purely combinational k-bit adder with carry in/out and status flags.
//   a_i, b_i       : addends
//   carryin_i      : carry in
//   sum_o          : k-bit sum
//   carryout_o     : carry out of the MSB
//   AddOverflow_o  : signed overflow
//   AddZero_o      : sum is all zeros
//   AddSign_o      : MSB of the sum
// -----------------------------------------------------------------------------
module adderk
  import mul_seq_pkg::*;
#(
  parameter int k = MUL_K
) (
  input  logic [k-1:0] a_i,
  input  logic [k-1:0] b_i,
  input  logic         carryin_i,
  output logic [k-1:0] sum_o,
  output logic         carryout_o,
  output logic         AddOverflow_o,
  output logic         AddZero_o,
  output logic         AddSign_o
);

  // Widen by one bit so the carry out falls into the MSB of the result.
  assign {carryout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{k{1'b0}}, carryin_i};

  // Overflow: both addends share a sign that the sum does not.
  assign AddOverflow_o = (a_i[k-1] == b_i[k-1]) && (sum_o[k-1] != a_i[k-1]);
  assign AddZero_o     = ~|sum_o;
  assign AddSign_o     = sum_o[k-1];

endmodule : adderk

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Sequential K x K shift-add multiplier, signed or unsigned.
// Operands are converted to magnitudes on start, multiplied in K RUN cycles
// using one K-bit adder, and the 2K-bit result is negated in FIX when the
// operand signs differ. done pulses for one cycle in DONE.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : mul_seq_if.slave (start/sgn/a/b in, busy/done/hi/lo/zero out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int K = MUL_K
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_seq_if.slave   bus
);

  localparam int CW = $clog2(K) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  // Magnitude of v when s marks it as signed; the most-negative value wraps
  // onto itself, which read unsigned is exactly 2^(K-1).
  function automatic logic [K-1:0] mag(input logic [K-1:0] v, input logic s);
    if (s && v[K-1]) begin
      return (~v) + {{(K-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  mul_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [K-1:0]  ma_q,    ma_d;
  logic          neg_q,   neg_d;
  logic [K-1:0]  hi_q,    hi_d;
  logic [K-1:0]  lo_q,    lo_d;
  logic          busy_q;
  logic          done_q;
  logic          zero_q;

  logic [K-1:0]   add_b_s;
  logic [K-1:0]   add_s_s;
  logic           add_c_s;
  logic [2*K-1:0] prod_neg_s;
  logic [2:0]     unused_flags_s;

  // Multiplicand is added only when the current multiplier bit is set.
  assign add_b_s    = lo_q[0] ? ma_q : {K{1'b0}};
  assign prod_neg_s = (~{hi_q, lo_q}) + {{(2*K-1){1'b0}}, 1'b1};

  adderk #(
    .k (K)
  ) u_adder (
    .a_i           (hi_q),
    .b_i           (add_b_s),
    .carryin_i     (1'b0),
    .sum_o         (add_s_s),
    .carryout_o    (add_c_s),
    .AddOverflow_o (unused_flags_s[0]),
    .AddZero_o     (unused_flags_s[1]),
    .AddSign_o     (unused_flags_s[2])
  );

  // Next-state and datapath update for the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ma_d    = mag(bus.a, bus.sgn);
          lo_d    = mag(bus.b, bus.sgn);
          hi_d    = {K{1'b0}};
          cnt_d   = {CW{1'b0}};
          neg_d   = bus.sgn & (bus.a[K-1] ^ bus.b[K-1]);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Partial sum and its carry shift right into the multiplier register.
        {hi_d, lo_d} = {add_c_s, add_s_s, lo_q[K-1:1]};
        cnt_d        = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        if (neg_q) begin
          {hi_d, lo_d} = prod_neg_s;
        end else begin
          {hi_d, lo_d} = {hi_q, lo_q};
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      ma_q    <= {K{1'b0}};
      neg_q   <= 1'b0;
      hi_q    <= {K{1'b0}};
      lo_q    <= {K{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      // Status flags are decoded from the next state so they line up with it.
      busy_q  <= (state_d == RUN) || (state_d == FIX);
      done_q  <= (state_d == DONE);
      zero_q  <= ~|{hi_d, lo_d};
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.zero = zero_q;

endmodule : mul_seq
